// File: rtl/vga_axil_regfile.sv
// AXI4-lite slave register file: NUM_REGS registers of DATA_W bits, per-register
// read-only override from ro_i, per-byte write strobes and a one-cycle write pulse.
module vga_axil_regfile #(
    parameter int                   ADDR_W    = 32,
    parameter int                   DATA_W    = 32,
    parameter int                   NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] cur,
                                                      input logic [DATA_W-1:0] upd,
                                                      input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < STRB_W; b++)
            if (strb[b]) res[b*8 +: 8] = upd[b*8 +: 8];
        return res;
    endfunction

    function automatic logic [ADDR_W-1:0] reg_index(input logic [ADDR_W-1:0] addr);
        return addr >> OFF_W;
    endfunction

    function automatic logic [1:0] write_resp(input logic in_range, input logic ro_hit);
        if (!in_range) return RESP_DECERR;
        if (ro_hit)    return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                 aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0]    aw_addr_q;
    logic [DATA_W-1:0]    w_data_q;
    logic [STRB_W-1:0]    w_strb_q;
    logic [ADDR_W-1:0]    wr_addr, wr_idx, rd_idx;
    logic [DATA_W-1:0]    wr_data, rd_val, rdata_q;
    logic [STRB_W-1:0]    wr_strb;
    logic                 wr_in_range;
    logic [NUM_REGS-1:0]  wr_hit, pulse_q;
    logic [1:0]           bresp_q, rresp_q, rd_resp;

    // Write channel control
    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        commit  = 1'b0;
        case (w_state)
            W_IDLE:    begin awready = !rst; wready = !rst; end
            W_HAVE_AW: wready  = !rst;
            W_HAVE_W:  awready = !rst;
            default:   ;
        endcase
        bvalid = (w_state == W_RESP) && !rst;
        aw_hs  = awvalid && awready;
        w_hs   = wvalid && wready;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_next = W_RESP;
                    commit = 1'b1;
                end else if (aw_hs) begin
                    w_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: if (w_hs)  begin w_next = W_RESP; commit = 1'b1; end
            W_HAVE_W:  if (aw_hs) begin w_next = W_RESP; commit = 1'b1; end
            W_RESP:    if (bvalid && bready) w_next = W_IDLE;
            default:   w_next = W_IDLE;
        endcase
    end

    // The completing handshake supplies its half live; the other half comes from the capture regs.
    always_comb begin
        wr_addr     = (w_state == W_HAVE_AW) ? aw_addr_q : awaddr;
        wr_data     = (w_state == W_HAVE_W)  ? w_data_q  : wdata;
        wr_strb     = (w_state == W_HAVE_W)  ? w_strb_q  : wstrb;
        wr_idx      = reg_index(wr_addr);
        wr_in_range = wr_idx < ADDR_W'(NUM_REGS);
        wr_hit      = '0;
        for (int i = 0; i < NUM_REGS; i++)
            wr_hit[i] = commit && (wr_idx == ADDR_W'(i));
    end

    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr_q <= awaddr;
        if (w_hs) begin
            w_data_q <= wdata;
            w_strb_q <= wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
            pulse_q <= '0;
        end else begin
            w_state <= w_next;
            pulse_q <= wr_hit & ~RO_MASK & {NUM_REGS{|wr_strb}};
            if (commit) bresp_q <= write_resp(wr_in_range, |(wr_hit & RO_MASK));
        end
    end

    assign bresp      = rst ? 2'b00 : bresp_q;
    assign wr_pulse_o = rst ? '0 : pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign regs_o[g*DATA_W +: DATA_W] = ro_i[g*DATA_W +: DATA_W];
        end else begin : g_rw
            logic [DATA_W-1:0] val;
            always_ff @(posedge clk) begin
                if (rst)            val <= RESET_VAL;
                else if (wr_hit[g]) val <= merge_bytes(val, wr_data, wr_strb);
            end
            assign regs_o[g*DATA_W +: DATA_W] = val;
        end
    end

    // Read channel: one-deep response register
    always_comb begin
        r_next  = r_state;
        arready = (r_state == R_IDLE) && !rst;
        rvalid  = (r_state == R_RESP) && !rst;
        ar_hs   = arvalid && arready;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (rvalid && rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_idx  = reg_index(araddr);
        rd_val  = '0;
        rd_resp = RESP_DECERR;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == ADDR_W'(i)) begin
                rd_val  = regs_o[i*DATA_W +: DATA_W];
                rd_resp = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_resp;
            end
        end
    end

    assign rdata = rst ? '0 : rdata_q;
    assign rresp = rst ? 2'b00 : rresp_q;

endmodule

// File: doc/vga_axil_regfile.md
VGA_AXIL_REGFILE -- requirements
Module: vga_axil_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning AXI4-lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; legal values are 32 and 64.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning register count; legal range is 1..256.
REQ-004 SHALL have parameter RO_MASK, default 0, meaning a NUM_REGS-bit mask; bit i set makes register i read-only and sourced from ro_i.
REQ-005 SHALL have parameter RESET_VAL, default 0, meaning the DATA_W-bit reset value of every writable register.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have AR-channel ports: araddr input ADDR_W, arvalid input 1, arready output 1.
REQ-009 SHALL have R-channel ports: rdata output DATA_W, rresp output 2, rvalid output 1, rready input 1.
REQ-010 SHALL have AW-channel ports: awaddr input ADDR_W, awvalid input 1, awready output 1.
REQ-011 SHALL have W-channel ports: wdata input DATA_W, wstrb input DATA_W/8, wvalid input 1, wready output 1.
REQ-012 SHALL have B-channel ports: bresp output 2, bvalid output 1, bready input 1.
REQ-013 SHALL have port regs_o, output, NUM_REGS*DATA_W: register i occupies bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port ro_i, input, NUM_REGS*DATA_W: read-only values, using the same packing as regs_o.
REQ-015 SHALL have port wr_pulse_o, output, NUM_REGS: one-cycle pulse per successful write to register i.

Function
REQ-016 SHALL decode index = addr >> log2(DATA_W/8); the low byte-offset bits are ignored.
REQ-017 SHALL respond DECERR (2'b11) when index >= NUM_REGS.
REQ-018 SHALL encode responses as OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
REQ-019 SHALL implement the write FSM with states W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
REQ-020 SHALL drive awready high in W_IDLE and W_HAVE_W, and low otherwise.
REQ-021 SHALL drive wready high in W_IDLE and W_HAVE_AW, and low otherwise.
REQ-022 SHALL capture awaddr on the AW handshake and wdata/wstrb on the W handshake, each held until the response completes.
REQ-023 SHALL make the following write-FSM transitions:
- W_IDLE: AW and W handshakes in the same cycle -> W_RESP; AW only -> W_HAVE_AW; W only -> W_HAVE_W.
- W_HAVE_AW or W_HAVE_W: completing handshake -> W_RESP.
REQ-024 SHALL commit the write on the clock edge of the completing handshake; the new value appears on regs_o the next cycle.
REQ-025 SHALL update only byte lanes whose wstrb bit is 1; wstrb=0 is an OKAY write with no change and no pulse.
REQ-026 SHALL treat a write to a RO_MASK register as follows: no update, no pulse, bresp=SLVERR.
REQ-027 SHALL treat an out-of-range write as follows: no update, no pulse, bresp=DECERR.
REQ-028 SHALL assert wr_pulse_o[i] for exactly the first W_RESP cycle after a successful write with wstrb != 0.
REQ-029 SHALL assert bvalid throughout W_RESP and hold bresp stable until the B handshake.
REQ-030 SHALL go W_RESP -> W_IDLE on the B handshake; awready and wready rise the following cycle, with no bypass.
REQ-031 SHALL implement the read FSM with states R_IDLE and R_RESP.
REQ-032 SHALL drive arready high only in R_IDLE.
REQ-033 SHALL latch rdata/rresp on the AR handshake and assert rvalid the next cycle, giving a latency of 1.
REQ-034 SHALL hold rvalid, rdata and rresp stable until the R handshake, then return to R_IDLE.
REQ-035 SHALL source rdata as follows: writable register -> current register value; RO register -> ro_i slice sampled at the AR handshake; out-of-range -> 0 with DECERR.
REQ-036 SHALL run the read and write paths independently, both operating in the same cycle without stall.
REQ-037 SHALL return the pre-write value when a read and a write to the same register commit on the same edge.
REQ-038 SHALL drive RO entries of regs_o with the corresponding ro_i slices, combinationally.

Reset
REQ-039 SHALL, while rst=1, force both FSMs to their IDLE states.
REQ-040 SHALL, while rst=1, drive arready, awready, wready, rvalid, bvalid and wr_pulse_o to 0.
REQ-041 SHALL, while rst=1, drive rdata, rresp and bresp to 0.
REQ-042 SHALL load all writable registers with RESET_VAL on a reset edge.
REQ-043 SHALL abort any in-flight transaction when rst is asserted mid-operation, with no partial write.
REQ-044 SHALL drive arready, awready and wready high in the first cycle after rst deasserts.

Verification
REQ-045 SHALL cover: write 0xDEADBEEF to 0x04 with wstrb=0xF -> bresp=OKAY, wr_pulse_o=8'b0000_0010 for 1 cycle; read 0x04 -> 0xDEADBEEF, OKAY.
REQ-046 SHALL cover: wvalid asserted 3 cycles before awvalid -> FSM passes W_HAVE_W, a single commit, bvalid 1 cycle after the AW handshake.
REQ-047 SHALL cover: reg1=0xDEADBEEF, then write 0x12345678 with wstrb=0x3 -> read returns 0xDEAD5678.
REQ-048 SHALL cover: write and read at 0x20 (NUM_REGS=8) -> bresp=DECERR, rresp=DECERR, rdata=0, all regs unchanged.
REQ-049 SHALL cover: RO_MASK=8'h04, ro_i reg2=0xCAFE0000; write 0x08 -> SLVERR, no pulse; read 0x08 -> 0xCAFE0000.
REQ-050 SHALL cover: bready held low 5 cycles, then rst pulsed while bvalid=1 -> bvalid=0 the next cycle, regs=RESET_VAL, readies high after rst deasserts.
